// File: rtl/fifo_flags_pkg.sv
// Shared constants for the flagged FIFO: read-mode selectors and depth helper.
package fifo_flags_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int depth_of(input int nb_addr);
        return 1 << nb_addr;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x NB_REG register file: synchronous write port, asynchronous read port.
module fifo_mem
    import fifo_flags_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [NB_ADDR-1:0] waddr,
    input  logic [NB_REG-1:0]  wdata,
    input  logic [NB_ADDR-1:0] raddr,
    output logic [NB_REG-1:0]  rdata
);

    localparam int DEPTH = depth_of(NB_ADDR);

    // Contents are deliberately left unreset; the pointers define validity.
    logic [NB_REG-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Synchronous FIFO with fill count, almost-full/empty thresholds, sticky
// overflow/underflow flags and a build-time standard or FWFT read mode.
module fifo_flags
    import fifo_flags_pkg::*;
#(
    parameter int NB_REG    = 32,
    parameter int NB_ADDR   = 3,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = depth_of(NB_ADDR) - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_wr,
    input  logic [NB_REG-1:0]   i_wdata,
    input  logic                i_rd,
    input  logic                i_clr_err,
    output logic [NB_REG-1:0]   o_rdata,
    output logic                o_empty,
    output logic                o_full,
    output logic                o_almost_full,
    output logic                o_almost_empty,
    output logic [NB_ADDR:0]    o_count,
    output logic                o_overflow,
    output logic                o_underflow
);

    localparam int DEPTH  = depth_of(NB_ADDR);
    localparam int NB_CNT = NB_ADDR + 1;

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [NB_ADDR-1:0] wr_ptr, rd_ptr;
    logic [NB_CNT-1:0]  count;
    logic [NB_REG-1:0]  head;
    logic               empty, full, rd_ok, wr_ok;

    assign empty = (count == '0);
    assign full  = (count == NB_CNT'(DEPTH));
    assign rd_ok = i_rd & ~empty;
    // A write into a full FIFO slips in only when a pop frees the slot this cycle.
    assign wr_ok = i_wr & (~full | rd_ok);

    fifo_mem #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (i_wdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + NB_ADDR'(1);
            if (rd_ok) rd_ptr <= rd_ptr + NB_ADDR'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + NB_CNT'(1);
                2'b01:   count <= count - NB_CNT'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_clr_err) begin
                o_overflow  <= 1'b0;
                o_underflow <= 1'b0;
            end
            if (i_wr & ~wr_ok) o_overflow  <= 1'b1;
            if (i_rd & ~rd_ok) o_underflow <= 1'b1;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign o_rdata = empty ? '0 : head;
    end else begin : g_std
        logic [NB_REG-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (i_rst)      rdata_q <= '0;
            else if (rd_ok) rdata_q <= head;
        end
        assign o_rdata = rdata_q;
    end

    assign o_empty        = empty;
    assign o_full         = full;
    assign o_almost_full  = (count >= NB_CNT'(AF_THRESH));
    assign o_almost_empty = (count <= NB_CNT'(AE_THRESH));
    assign o_count        = count;

endmodule
